// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI mode-0 slave endpoint.
package spi_pkg;

  localparam int SPI_DATA_W_DEF = 8;
  localparam logic [SPI_DATA_W_DEF-1:0] SPI_IDLE_PATTERN_DEF = 8'hFF;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with a history flop for edge flags.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SPI_SYNC_STAGES-1:0] chain_q;
  logic                       hist_q;

  // The reset level matches the pin's idle level so that reset never creates a fake edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {SPI_SYNC_STAGES{RESET_VAL}};
      hist_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[SPI_SYNC_STAGES-2:0], pin_i};
      hist_q  <= chain_q[SPI_SYNC_STAGES-1];
    end
  end

  assign sync_o = chain_q[SPI_SYNC_STAGES-1];
  assign rise_o = sync_o & ~hist_q;
  assign fall_o = ~sync_o & hist_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave endpoint: synchronised pins, MSB-first shifting, one-entry TX buffer.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int                DATA_W       = SPI_DATA_W_DEF,
  parameter logic [DATA_W-1:0] IDLE_PATTERN = SPI_IDLE_PATTERN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  spi_state_e        state_q, state_d;
  logic              armed_q, armed_d;
  logic [1:0]        settleCnt_q, settleCnt_d;
  logic              bufFull_q, bufFull_d;
  logic [DATA_W-1:0] txBuf_q, txBuf_d;
  logic [DATA_W-1:0] txShift_q, txShift_d;
  logic [DATA_W-1:0] rxShift_q, rxShift_d;
  logic [DATA_W-1:0] rxData_q, rxData_d;
  logic              rxValid_q, rxValid_d;
  logic              underrun_q, underrun_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [SPI_SYNC_STAGES-1:0] mosiChain_q;

  logic unusedSclkLevel;
  logic sclkRise, sclkFall;
  logic csSync, csRise, csFall;
  logic mosiSync, settled, active;
  logic csStart, csStop, sclkRiseAct, sclkFallAct;
  logic loadWord, wordDone, txWrite;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclkSync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (sclk),
    .sync_o (unusedSclkLevel),
    .rise_o (sclkRise),
    .fall_o (sclkFall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_csSync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (cs_n),
    .sync_o (csSync),
    .rise_o (csRise),
    .fall_o (csFall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosiChain_q <= '0;
    else     mosiChain_q <= {mosiChain_q[SPI_SYNC_STAGES-2:0], mosi};
  end

  // Arming waits until the sync chain holds real pin samples, not its reset seed.
  assign mosiSync    = mosiChain_q[SPI_SYNC_STAGES-1];
  assign settled     = (settleCnt_q == 2'(SPI_SYNC_STAGES));
  assign active      = (state_q == ST_ACTIVE);
  assign csStart     = !active && csFall && armed_q;
  assign csStop      = active && csRise;
  assign sclkRiseAct = active && !csRise && sclkRise;
  assign sclkFallAct = active && !csRise && sclkFall;
  assign loadWord    = csStart || (sclkFallAct && (bitCnt_q == '0));
  assign wordDone    = sclkRiseAct && (bitCnt_q == CNT_W'(DATA_W - 1));
  assign txWrite     = tx_valid && !bufFull_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (csFall && armed_q) state_d = ST_ACTIVE;
      ST_ACTIVE: if (csRise)            state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_ACTIVE);
    miso = (state_q == ST_ACTIVE) & txShift_q[DATA_W-1];
  end

  always_comb begin
    armed_d     = armed_q | (settled & csSync);
    settleCnt_d = settled ? settleCnt_q : settleCnt_q + 2'd1;
    bufFull_d   = bufFull_q;
    txBuf_d     = txBuf_q;
    txShift_d   = txShift_q;
    rxShift_d   = rxShift_q;
    rxData_d    = rxData_q;
    bitCnt_d    = bitCnt_q;
    rxValid_d   = 1'b0;
    underrun_d  = 1'b0;

    // A load uses the pre-write buffer state, so a same-cycle write lands for the next word.
    if (loadWord) begin
      txShift_d  = bufFull_q ? txBuf_q : IDLE_PATTERN;
      underrun_d = !bufFull_q;
      bufFull_d  = 1'b0;
    end else if (sclkFallAct) begin
      txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
    end

    if (txWrite) begin
      bufFull_d = 1'b1;
      txBuf_d   = tx_data;
    end

    if (csStart || csStop) begin
      bitCnt_d  = '0;
      rxShift_d = '0;
    end

    if (sclkRiseAct) begin
      rxShift_d = {rxShift_q[DATA_W-2:0], mosiSync};
      if (wordDone) begin
        rxData_d  = {rxShift_q[DATA_W-2:0], mosiSync};
        rxValid_d = 1'b1;
        bitCnt_d  = '0;
      end else begin
        bitCnt_d = bitCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q     <= 1'b0;
      settleCnt_q <= '0;
      bufFull_q   <= 1'b0;
      txBuf_q     <= '0;
      txShift_q   <= '0;
      rxShift_q   <= '0;
      rxData_q    <= '0;
      rxValid_q   <= 1'b0;
      underrun_q  <= 1'b0;
      bitCnt_q    <= '0;
    end else begin
      armed_q     <= armed_d;
      settleCnt_q <= settleCnt_d;
      bufFull_q   <= bufFull_d;
      txBuf_q     <= txBuf_d;
      txShift_q   <= txShift_d;
      rxShift_q   <= rxShift_d;
      rxData_q    <= rxData_d;
      rxValid_q   <= rxValid_d;
      underrun_q  <= underrun_d;
      bitCnt_q    <= bitCnt_d;
    end
  end

  assign tx_ready    = !bufFull_q;
  assign rx_data     = rxData_q;
  assign rx_valid    = rxValid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a mode-0 master model drives frames and checks both directions.
module tb_spi_slave_if;

  localparam int HALF = 4;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;

  int         checks;
  int         failures;
  int         rxCount;
  int         underrunCount;
  int         busyCount;
  logic [7:0] rxLog [0:31];
  logic       readyAtStart;
  logic       busyAtStart;
  logic [15:0] misoWord;
  logic       dummy;
  int         rx0;
  int         ur0;
  int         busy0;

  spi_slave_if dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .mosi        (mosi),
    .cs_n        (cs_n),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .tx_underrun (tx_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulses on the falling clock edge, well away from the DUT's active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (rxCount < 32) rxLog[rxCount] = rx_data;
      rxCount = rxCount + 1;
    end
    if (tx_underrun) underrunCount = underrunCount + 1;
    if (busy) busyCount = busyCount + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, wanted finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic writeTx(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 300) begin
      waitClk(1);
      n++;
    end
    checkOutput("write_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    waitClk(1);
    tx_valid = 1'b0;
  endtask

  task automatic spiBit(input logic b, input bit last, output logic m);
    mosi = b;
    waitClk(HALF);
    m    = miso;
    sclk = 1'b1;
    waitClk(HALF);
    if (!last) sclk = 1'b0;
  endtask

  // One CS window; the final sclk fall coincides with the CS rise so no trailing word load occurs.
  task automatic applyStimulus(input logic [15:0] mosiWord, input int nbits, input bit collide,
                               input logic [7:0] collideData, output logic [15:0] misoOut);
    logic m;
    misoOut = '0;
    waitClk(5);
    cs_n = 1'b0;
    if (collide) begin
      waitClk(2);
      tx_data  = collideData;
      tx_valid = 1'b1;
      waitClk(1);
      tx_valid = 1'b0;
      waitClk(5);
    end else begin
      waitClk(8);
    end
    readyAtStart = tx_ready;
    busyAtStart  = busy;
    for (int i = nbits - 1; i >= 0; i--) begin
      spiBit(mosiWord[i], (i == 0), m);
      misoOut[i] = m;
    end
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    waitClk(3);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rxCount       = 0;
    underrunCount = 0;
    busyCount     = 0;
    rst      = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    cs_n     = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    waitClk(3);

    checkOutput("rst_miso",     {31'd0, miso},        32'd0);
    checkOutput("rst_rx_data",  {24'd0, rx_data},     32'd0);
    checkOutput("rst_rx_valid", {31'd0, rx_valid},    32'd0);
    checkOutput("rst_tx_ready", {31'd0, tx_ready},    32'd1);
    checkOutput("rst_busy",     {31'd0, busy},        32'd0);
    checkOutput("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    rst = 1'b0;
    waitClk(5);

    // Single word with a preloaded TX word.
    writeTx(8'hA5);
    checkOutput("t1_ready_low", {31'd0, tx_ready}, 32'd0);
    rx0 = rxCount;
    ur0 = underrunCount;
    applyStimulus(16'h003C, 8, 1'b0, 8'h00, misoWord);
    checkOutput("t1_miso",        {16'd0, misoWord},       32'h00A5);
    checkOutput("t1_rx_count",    rxCount - rx0,           32'd1);
    checkOutput("t1_rx_data",     {24'd0, rxLog[rx0]},     32'h3C);
    checkOutput("t1_ready_start", {31'd0, readyAtStart},   32'd1);
    checkOutput("t1_busy_start",  {31'd0, busyAtStart},    32'd1);
    checkOutput("t1_underrun",    underrunCount - ur0,     32'd0);
    checkOutput("t1_busy_end",    {31'd0, busy},           32'd0);

    // Back-to-back words, second TX word written once the first is consumed.
    writeTx(8'h11);
    rx0 = rxCount;
    ur0 = underrunCount;
    fork
      applyStimulus(16'hC35A, 16, 1'b0, 8'h00, misoWord);
      writeTx(8'h22);
    join
    checkOutput("t2_miso",     {16'd0, misoWord},       32'h1122);
    checkOutput("t2_rx_count", rxCount - rx0,           32'd2);
    checkOutput("t2_rx_word0", {24'd0, rxLog[rx0]},     32'hC3);
    checkOutput("t2_rx_word1", {24'd0, rxLog[rx0 + 1]}, 32'h5A);
    checkOutput("t2_underrun", underrunCount - ur0,     32'd0);

    // Underrun: nothing buffered.
    rx0 = rxCount;
    ur0 = underrunCount;
    applyStimulus(16'h000F, 8, 1'b0, 8'h00, misoWord);
    checkOutput("t3_miso",     {16'd0, misoWord},   32'h00FF);
    checkOutput("t3_underrun", underrunCount - ur0, 32'd1);
    checkOutput("t3_rx_data",  {24'd0, rx_data},    32'h0F);
    checkOutput("t3_rx_count", rxCount - rx0,       32'd1);

    // Abort after five rising edges, then a clean frame.
    rx0 = rxCount;
    applyStimulus(16'h001F, 5, 1'b0, 8'h00, misoWord);
    checkOutput("t4_rx_count", rxCount - rx0,    32'd0);
    checkOutput("t4_busy",     {31'd0, busy},    32'd0);
    checkOutput("t4_rx_data",  {24'd0, rx_data}, 32'h0F);
    rx0 = rxCount;
    applyStimulus(16'h0096, 8, 1'b0, 8'h00, misoWord);
    checkOutput("t4_next_rx",   {24'd0, rxLog[rx0]}, 32'h96);
    checkOutput("t4_next_miso", {16'd0, misoWord},   32'h00FF);

    // Reset in the middle of a frame with cs_n still low.
    waitClk(5);
    cs_n = 1'b0;
    waitClk(8);
    writeTx(8'h5C);
    checkOutput("t5_ready_full", {31'd0, tx_ready}, 32'd0);
    spiBit(1'b1, 1'b0, dummy);
    spiBit(1'b0, 1'b0, dummy);
    spiBit(1'b1, 1'b0, dummy);
    rst = 1'b1;
    waitClk(1);
    checkOutput("t5_miso",     {31'd0, miso},        32'd0);
    checkOutput("t5_rx_data",  {24'd0, rx_data},     32'd0);
    checkOutput("t5_rx_valid", {31'd0, rx_valid},    32'd0);
    checkOutput("t5_tx_ready", {31'd0, tx_ready},    32'd1);
    checkOutput("t5_busy",     {31'd0, busy},        32'd0);
    checkOutput("t5_underrun", {31'd0, tx_underrun}, 32'd0);
    rst   = 1'b0;
    rx0   = rxCount;
    busy0 = busyCount;
    for (int i = 4; i >= 0; i--) spiBit(i[0], (i == 0), dummy);
    sclk = 1'b0;
    cs_n = 1'b1;
    waitClk(3);
    checkOutput("t5_no_rx",   rxCount - rx0,     32'd0);
    checkOutput("t5_no_busy", busyCount - busy0, 32'd0);
    rx0 = rxCount;
    applyStimulus(16'h00E7, 8, 1'b0, 8'h00, misoWord);
    checkOutput("t5_next_rx",   {24'd0, rxLog[rx0]}, 32'hE7);
    checkOutput("t5_next_miso", {16'd0, misoWord},   32'h00FF);

    // TX write in the exact cycle of the CS-fall load with an empty buffer.
    rx0 = rxCount;
    ur0 = underrunCount;
    applyStimulus(16'h1234, 16, 1'b1, 8'h77, misoWord);
    checkOutput("t6_miso",        {16'd0, misoWord},       32'hFF77);
    checkOutput("t6_underrun",    underrunCount - ur0,     32'd1);
    checkOutput("t6_ready_start", {31'd0, readyAtStart},   32'd0);
    checkOutput("t6_rx_word0",    {24'd0, rxLog[rx0]},     32'h12);
    checkOutput("t6_rx_word1",    {24'd0, rxLog[rx0 + 1]}, 32'h34);
    checkOutput("t6_ready_end",   {31'd0, tx_ready},       32'd1);

    waitClk(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
